alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_decode.sv | 49 ++++
 rtl/alu_mc.sv | 215 +++++++++++++++++++++
 tb/tb_alu_mc.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM states
// and the decoded-control word handed from alu_decode to the datapath.
package alu_pkg;

   // Single-cycle class (bit 3 clear)
   localparam logic [3:0] OP_ADDU  = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_OR    = 4'b0010;
   localparam logic [3:0] OP_AND   = 4'b0011;
   localparam logic [3:0] OP_SUBU  = 4'b0100;
   localparam logic [3:0] OP_SUB   = 4'b0101;
   localparam logic [3:0] OP_SLTU  = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   // Iterative class (bit 3 set)
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_MULT  = 4'b1001;
   localparam logic [3:0] OP_DIVU  = 4'b1100;
   localparam logic [3:0] OP_DIV   = 4'b1101;

   // Single-cycle result selector
   localparam logic [1:0] SEL_ARITH = 2'b00;
   localparam logic [1:0] SEL_OR    = 2'b01;
   localparam logic [1:0] SEL_AND   = 2'b10;
   localparam logic [1:0] SEL_SLT   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ONE  = 2'b01,
      ST_ITER = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   // nop marks undefined iterative codes, which finish in one cycle with 0
   typedef struct packed {
      logic       sub;
      logic       ovchk;
      logic       sgn;
      logic [1:0] opsel;
      logic       iter;
      logic       div;
      logic       nop;
   } ctl_t;

endpackage

// File: rtl/alu_decode.sv
// Operation decoder: the only place where ALUctr bits are given meaning.
module alu_decode
   import alu_pkg::*;
(
   input  logic [3:0] i_alu_ctr,
   output ctl_t       o_ctl
);

   // Map the 4-bit code onto the control word; unknown codes become nop
   always_comb begin
      o_ctl = '0;
      case (i_alu_ctr)
         OP_ADDU:  o_ctl.opsel = SEL_ARITH;
         OP_ADD:   o_ctl.ovchk = 1'b1;
         OP_OR:    o_ctl.opsel = SEL_OR;
         OP_AND:   o_ctl.opsel = SEL_AND;
         OP_SUBU:  o_ctl.sub   = 1'b1;
         OP_SUB: begin
            o_ctl.sub   = 1'b1;
            o_ctl.ovchk = 1'b1;
         end
         OP_SLTU: begin
            o_ctl.sub   = 1'b1;
            o_ctl.opsel = SEL_SLT;
         end
         OP_SLT: begin
            o_ctl.sub   = 1'b1;
            o_ctl.sgn   = 1'b1;
            o_ctl.opsel = SEL_SLT;
         end
         OP_MULTU: o_ctl.iter = 1'b1;
         OP_MULT: begin
            o_ctl.iter = 1'b1;
            o_ctl.sgn  = 1'b1;
         end
         OP_DIVU: begin
            o_ctl.iter = 1'b1;
            o_ctl.div  = 1'b1;
         end
         OP_DIV: begin
            o_ctl.iter = 1'b1;
            o_ctl.div  = 1'b1;
            o_ctl.sgn  = 1'b1;
         end
         default:  o_ctl.nop = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: one-cycle logic/arith ops plus bit-serial shift-add
// multiply and restoring divide, all sharing a single WIDTH-bit adder.
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       ALUctr,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] Hi,
   output logic             Zero,
   output logic             Overflow,
   output logic             DivZero
);
   import alu_pkg::*;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   ctl_t             w_ctl;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_acc;      // product high half / partial remainder
   logic [WIDTH-1:0] r_q;        // multiplier / dividend-quotient
   logic [WIDTH-1:0] r_m;        // multiplicand / divisor (magnitudes)
   logic             r_div, r_neg_q, r_neg_r, r_dz_pend;
   logic             r_busy, r_done, r_zero, r_ovf, r_dz;
   logic [WIDTH-1:0] r_result, r_hi;

   alu_decode u_decode (
      .i_alu_ctr (ALUctr),
      .o_ctl     (w_ctl)
   );

   // ---------------- shared adder/subtractor ----------------
   logic [WIDTH-1:0] w_add_x, w_add_y, w_add_y_eff;
   logic             w_add_sub;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_div_shift;

   assign w_div_shift = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};

   // Adder operands come from the ports when idle, from the iteration regs otherwise
   always_comb begin
      w_add_x   = A;
      w_add_y   = B;
      w_add_sub = w_ctl.sub;
      if (r_state == ST_ITER) begin
         w_add_y   = r_m;
         w_add_x   = r_div ? w_div_shift : r_acc;
         w_add_sub = r_div;
      end
   end

   assign w_add_y_eff = w_add_y ^ {WIDTH{w_add_sub}};
   assign w_sum = {1'b0, w_add_x} + {1'b0, w_add_y_eff} + {{WIDTH{1'b0}}, w_add_sub};

   // ---------------- single-cycle result ----------------
   logic             w_ovf_raw, w_less, w_one_ovf;
   logic [WIDTH-1:0] w_one_res;

   // Overflow when both addends share a sign that the sum does not keep
   assign w_ovf_raw = (A[WIDTH-1] == w_add_y_eff[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
   assign w_less    = w_ctl.sgn ? (w_sum[WIDTH-1] ^ w_ovf_raw) : ~w_sum[WIDTH];
   assign w_one_ovf = w_ctl.ovchk & w_ovf_raw & ~w_ctl.nop;

   // Select the single-cycle result by opsel; undefined codes yield zero
   always_comb begin
      case (w_ctl.opsel)
         SEL_OR:  w_one_res = A | B;
         SEL_AND: w_one_res = A & B;
         SEL_SLT: w_one_res = {{(WIDTH-1){1'b0}}, w_less};
         default: w_one_res = w_sum[WIDTH-1:0];
      endcase
      if (w_ctl.nop) w_one_res = '0;
   end

   // ---------------- iteration step and final sign fix ----------------
   logic [WIDTH-1:0] w_abs_a, w_abs_b, w_acc_n, w_q_n;
   logic [WIDTH-1:0] w_fin_res, w_fin_hi;
   logic [WIDTH:0]   w_madd;
   logic             w_ge;

   assign w_abs_a = (w_ctl.sgn && A[WIDTH-1]) ? -A : A;
   assign w_abs_b = (w_ctl.sgn && B[WIDTH-1]) ? -B : B;
   assign w_madd  = r_q[0] ? w_sum : {1'b0, r_acc};
   // Trial subtraction succeeds if the shifted remainder overflowed WIDTH bits or no borrow
   assign w_ge    = r_acc[WIDTH-1] | w_sum[WIDTH];

   // One multiply (shift-add) or divide (restoring) step per cycle
   always_comb begin
      if (r_div) begin
         w_acc_n = w_ge ? w_sum[WIDTH-1:0] : w_div_shift;
         w_q_n   = {r_q[WIDTH-2:0], w_ge};
      end else begin
         w_acc_n = w_madd[WIDTH:1];
         w_q_n   = {w_madd[0], r_q[WIDTH-1:1]};
      end
   end

   // Restore signs on the unsigned core result after the last step
   always_comb begin
      if (r_div) begin
         w_fin_res = r_neg_q ? -w_q_n : w_q_n;
         w_fin_hi  = r_neg_r ? -w_acc_n : w_acc_n;
      end else begin
         {w_fin_hi, w_fin_res} = r_neg_q ? -{w_acc_n, w_q_n} : {w_acc_n, w_q_n};
      end
   end

   // Control FSM with registered outputs and iteration datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_q       <= '0;
         r_m       <= '0;
         r_div     <= 1'b0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_dz_pend <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= '0;
         r_hi      <= '0;
         r_zero    <= 1'b0;
         r_ovf     <= 1'b0;
         r_dz      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_cnt   <= '0;
                  r_div   <= w_ctl.div;
                  r_neg_q <= w_ctl.sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                  r_neg_r <= w_ctl.sgn & A[WIDTH-1];
                  if (w_ctl.iter) begin
                     r_busy <= 1'b1;
                     if (w_ctl.div && (B == '0)) begin
                        r_q       <= A;
                        r_dz_pend <= 1'b1;
                        r_state   <= ST_DONE;
                     end else begin
                        r_acc   <= '0;
                        r_q     <= w_abs_a;
                        r_m     <= w_abs_b;
                        r_state <= ST_ITER;
                     end
                  end else begin
                     r_result <= w_one_res;
                     r_hi     <= '0;
                     r_zero   <= (w_one_res == '0);
                     r_ovf    <= w_one_ovf;
                     r_dz     <= 1'b0;
                     r_done   <= 1'b1;
                     r_state  <= ST_ONE;
                  end
               end
            end
            ST_ONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            ST_ITER: begin
               r_acc <= w_acc_n;
               r_q   <= w_q_n;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_CNT) begin
                  r_result <= w_fin_res;
                  r_hi     <= w_fin_hi;
                  r_zero   <= (w_fin_res == '0);
                  r_ovf    <= 1'b0;
                  r_dz     <= 1'b0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state   <= ST_IDLE;
               r_busy    <= 1'b0;
               r_dz_pend <= 1'b0;
               // Divide-by-zero arrives here straight from IDLE with its result still pending
               if (r_dz_pend) begin
                  r_result <= '1;
                  r_hi     <= r_q;
                  r_zero   <= 1'b0;
                  r_ovf    <= 1'b0;
                  r_dz     <= 1'b1;
                  r_done   <= 1'b1;
               end else begin
                  r_done <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign Result   = r_result;
   assign Hi       = r_hi;
   assign Zero     = r_zero;
   assign Overflow = r_ovf;
   assign DivZero  = r_dz;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32.
module tb_alu_mc;
   import alu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   ALUctr = 4'h0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         busy, done, Zero, Overflow, DivZero;
   logic [W-1:0] Result, Hi;

   int total = 0;
   int bad   = 0;
   int lat, bcnt, ndone;

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .ALUctr   (ALUctr),
      .A        (A),
      .B        (B),
      .busy     (busy),
      .done     (done),
      .Result   (Result),
      .Hi       (Hi),
      .Zero     (Zero),
      .Overflow (Overflow),
      .DivZero  (DivZero)
   );

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [W-1:0] res, input logic [W-1:0] hi,
                          input logic z, input logic ov, input logic dz);
      check({tag, ".Result"},   Result,   res);
      check({tag, ".Hi"},       Hi,       hi);
      check({tag, ".Zero"},     Zero,     z);
      check({tag, ".Overflow"}, Overflow, ov);
      check({tag, ".DivZero"},  DivZero,  dz);
      $display("%s: Result=%h Hi=%h Z=%0b V=%0b DZ=%0b", tag, Result, Hi, Zero, Overflow, DivZero);
   endtask

   // Issue one operation, scramble the operand inputs after acceptance, and
   // wait (bounded) for done. lat counts clock edges from the accepting edge.
   task automatic run_op(input string tag, input logic [3:0] ctr, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit inject,
                         output int lat_o, output int busy_o);
      int n;
      start = 1'b0;
      cyc;
      ALUctr = ctr;
      A      = a;
      B      = b;
      start  = 1'b1;
      cyc;
      n      = 1;
      busy_o = 0;
      start  = 1'b0;
      A      = 32'hDEAD_BEEF;
      B      = 32'h0BAD_F00D;
      while (!done && n < 100) begin
         if (busy) busy_o++;
         if (inject && n == 5) begin
            start  = 1'b1;
            ALUctr = OP_ADDU;
         end else begin
            start = 1'b0;
         end
         cyc;
         n++;
      end
      start = 1'b0;
      lat_o = n;
      check({tag, ".done_seen"}, done, 1'b1);
      check({tag, ".busy_at_done"}, busy, 1'b0);
   endtask

   initial begin
      // Reset, with a start request that must be ignored while rst_n is low
      rst_n  = 1'b0;
      start  = 1'b1;
      ALUctr = OP_ADD;
      A      = 32'd1;
      B      = 32'd1;
      cyc;
      cyc;
      check("reset.done", done, 1'b0);
      check("reset.busy", busy, 1'b0);
      chk_out("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
      rst_n = 1'b1;
      cyc;
      check("post_reset.done", done, 1'b0);

      // Signed add overflow, one-cycle latency
      run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, lat, bcnt);
      check("add_ovf.latency", lat, 1);
      chk_out("add_ovf", 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0);
      cyc;
      check("add_ovf.done_pulse", done, 1'b0);
      check("add_ovf.hold", Result, 32'h8000_0000);

      run_op("addu", OP_ADDU, 32'h7FFF_FFFF, 32'h1, 1'b0, lat, bcnt);
      chk_out("addu", 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0);

      run_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 1'b0, lat, bcnt);
      chk_out("sub_ovf", 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0);

      run_op("subu", OP_SUBU, 32'h8000_0000, 32'h1, 1'b0, lat, bcnt);
      chk_out("subu", 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);

      run_op("or", OP_OR, 32'hF0F0_0000, 32'h0FF0_00FF, 1'b0, lat, bcnt);
      check("or.Result", Result, 32'hFFF0_00FF);
      run_op("and", OP_AND, 32'hF0F0_0000, 32'h0FF0_00FF, 1'b0, lat, bcnt);
      check("and.Result", Result, 32'h00F0_0000);

      run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 1'b0, lat, bcnt);
      chk_out("slt", 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
      run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 1'b0, lat, bcnt);
      chk_out("sltu", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Undefined iterative-class code finishes in one cycle with zero
      run_op("undef", 4'b1010, 32'h1234_5678, 32'h1, 1'b0, lat, bcnt);
      check("undef.latency", lat, 1);
      chk_out("undef", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Signed multiply with a start pulse injected mid-iteration
      run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, lat, bcnt);
      check("mult.latency", lat, 33);
      check("mult.busy_cycles", bcnt, 32);
      chk_out("mult", 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      ndone = 0;
      for (int i = 0; i < 4; i++) begin
         cyc;
         if (done) ndone++;
      end
      check("mult.no_second_done", ndone, 0);
      check("mult.hold", Result, 32'hFFFF_FFEB);

      run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bcnt);
      check("multu.latency", lat, 33);
      chk_out("multu", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

      run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bcnt);
      check("div.latency", lat, 33);
      chk_out("div", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

      run_op("divu", OP_DIVU, 32'd100, 32'd7, 1'b0, lat, bcnt);
      chk_out("divu", 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);

      run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 1'b0, lat, bcnt);
      check("divu_zero.latency", lat, 2);
      check("divu_zero.busy_cycles", bcnt, 1);
      chk_out("divu_zero", 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0, 1'b1);

      run_op("div_minneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bcnt);
      chk_out("div_minneg", 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a multu aborts it without a done pulse
      start = 1'b0;
      cyc;
      ALUctr = OP_MULTU;
      A      = 32'h0001_2345;
      B      = 32'h0000_0777;
      start  = 1'b1;
      cyc;
      start  = 1'b0;
      repeat (10) cyc;
      check("abort.busy_before", busy, 1'b1);
      rst_n = 1'b0;
      cyc;
      rst_n = 1'b1;
      check("abort.busy", busy, 1'b0);
      check("abort.done", done, 1'b0);
      chk_out("abort", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         cyc;
         if (done || busy) ndone++;
      end
      check("abort.quiet", ndone, 0);

      run_op("multu_after", OP_MULTU, 32'd6, 32'd7, 1'b0, lat, bcnt);
      check("multu_after.latency", lat, 33);
      chk_out("multu_after", 32'd42, 32'h0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
